mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage between the EX/MEM pipe register and writeback.
- Consumes the EX/MEM outputs (ALU result, store data, control, destination register).
- Runs load/store transactions on a req/ready data-memory bus and stalls upstream while a transaction is pending.
- Registers the writeback result and its control, so it also acts as the MEM/WB pipe register.

Parameters:
ADDR_W, 10, word-address width on dmem_addr
TIMEOUT_CYC, 16, cycles in WAIT before abort (DMEM_TIMEOUT_EN only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
alu_result_in  in  32  ALU result / byte address
store_data_in  in  32  store data
reg_wen_in  in  1  register write enable
dmem_alu_in  in  1  1 = load (writeback from memory), 0 = writeback ALU result
mem_wen_in  in  1  1 = store
jr_in  in  1  jump-register flag, passed through
regd_in  in  5  destination register
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, registered
dmem_addr  out  ADDR_W  word address = alu_result_in[ADDR_W+1:2], registered
dmem_wdata  out  32  store data, registered
dmem_rdata  in  32  read data, valid when dmem_ready=1
dmem_ready  in  1  transaction complete this cycle
stall_out  out  1  hold upstream stages and EX/MEM register
wb_data_out  out  32  writeback data
reg_wen_out  out  1  writeback enable
jr_out  out  1  jump-register flag
regd_out  out  5  writeback register
dmem_err_out  out  1  sticky timeout error

Behaviour:
- Reset: every registered output, including dmem_err_out, is 0; FSM goes to IDLE.
- Reset has priority over everything.
- mem_op = dmem_alu_in | mem_wen_in.
- States: IDLE, WAIT.
- IDLE, mem_op=0 (pass-through):
  - At the next edge: wb_data_out<=alu_result_in, reg_wen_out<=reg_wen_in, jr_out<=jr_in, regd_out<=regd_in.
  - Latency 1 cycle; stall_out=0.
- IDLE, mem_op=1:
  - stall_out=1 combinationally.
  - At the next edge:
    - Capture all inputs.
    - dmem_req<=1, dmem_we<=mem_wen_in, dmem_addr and dmem_wdata loaded.
    - Emit a bubble: reg_wen_out<=0, jr_out<=0, regd_out<=0, wb_data_out<=0.
    - Go to WAIT.
- WAIT:
  - stall_out = ~dmem_ready.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - Each cycle with dmem_ready=0, a bubble is emitted.
- WAIT with dmem_ready=1, at that edge:
  - dmem_req<=0.
  - wb_data_out <= dmem_rdata if load, else the captured ALU result.
  - reg_wen_out, jr_out and regd_out are loaded from captured values.
  - Go to IDLE. Upstream advances on the same edge.
- Minimum memory-op latency is 2 cycles: ready asserted in the first WAIT cycle.
- dmem_ready while dmem_req=0 is ignored.
- dmem_alu_in=1 and mem_wen_in=1 together: treated as a store; wb_data_out = ALU result.
- Address bits [1:0] are ignored. No alignment check.
- Back-to-back memory ops: IDLE for 1 cycle between them. IDLE with mem_op=1 re-enters WAIT.
- rst asserted during WAIT: dmem_req=0 from the next cycle. The outstanding transaction is abandoned, and the memory must tolerate a dropped request.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With it defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle with dmem_ready=0.
  - When the count reaches TIMEOUT_CYC-1 with dmem_ready still 0, the next edge: dmem_req<=0, bubble emitted (reg_wen_out=0), dmem_err_out<=1 (sticky until rst), IDLE.
  - stall_out=0 in that final cycle.
- Without it: WAIT never exits except on dmem_ready or rst; the counter is absent; dmem_err_out is tied 0.

Test Plan:
- ALU op, alu_result_in=0x1234, reg_wen_in=1, regd_in=5 -> next cycle wb_data_out=0x1234, reg_wen_out=1, regd_out=5; stall_out never 1.
- Load from address 0x40, ready at 3rd WAIT cycle, rdata=0xDEADBEEF:
  - dmem_addr=0x10, dmem_we=0.
  - stall_out=1 for 3 cycles.
  - Then wb_data_out=0xDEADBEEF, reg_wen_out=1; bubbles (reg_wen_out=0) before that.
- Store to 0x8 with data 0xA5A5A5A5, ready in first WAIT cycle -> dmem_we=1, dmem_addr=2, dmem_wdata=0xA5A5A5A5; req high exactly 1 cycle; total stall 1 cycle.
- Load, then store, then ALU op back-to-back -> two separate transactions, correct order, one IDLE cycle between; ALU result one cycle after the store completes.
- rst pulsed in the 2nd WAIT cycle -> dmem_req=0 next cycle; all outputs 0; a later ALU op passes normally.
- DMEM_TIMEOUT_EN, TIMEOUT_CYC=16, ready held 0:
  - dmem_req drops after 16 WAIT cycles; dmem_err_out=1 and stays 1; reg_wen_out=0; stall released.
  - dmem_err_out clears only on rst.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage doubling as the MEM/WB register; runs loads/stores on a req/ready bus.
// Optional timeout (macro DMEM_TIMEOUT_EN) aborts a stuck WAIT and raises a sticky error.
module mem_stage #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic              reg_wen_in,
  input  logic              dmem_alu_in,
  input  logic              mem_wen_in,
  input  logic              jr_in,
  input  logic [4:0]        regd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_out,
  output logic [31:0]       wb_data_out,
  output logic              reg_wen_out,
  output logic              jr_out,
  output logic [4:0]        regd_out,
  output logic              dmem_err_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q;
  logic              mem_op;
  logic              timeout_hit;

  logic [31:0]       alu_q;
  logic              load_q;
  logic              reg_wen_q;
  logic              jr_q;
  logic [4:0]        regd_q;

  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [31:0]       dmem_wdata_q;

  logic [31:0]       wb_data_q;
  logic              reg_wen_out_q;
  logic              jr_out_q;
  logic [4:0]        regd_out_q;

  assign mem_op = dmem_alu_in | mem_wen_in;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit  = (state_q == S_WAIT) && !dmem_ready &&
                        (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign dmem_err_out = err_q;

  // Counter sits at zero in IDLE, so it starts fresh on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (!dmem_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign dmem_err_out = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  // The cycle that aborts on timeout releases the stall so upstream moves on.
  always_comb begin
    stall_out = 1'b0;
    case (state_q)
      S_IDLE:  stall_out = mem_op;
      S_WAIT:  stall_out = ~dmem_ready & ~timeout_hit;
      default: stall_out = 1'b0;
    endcase
  end

  // Writeback outputs default to a bubble; only pass-through and completion override it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      alu_q         <= '0;
      load_q        <= 1'b0;
      reg_wen_q     <= 1'b0;
      jr_q          <= 1'b0;
      regd_q        <= '0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      wb_data_q     <= '0;
      reg_wen_out_q <= 1'b0;
      jr_out_q      <= 1'b0;
      regd_out_q    <= '0;
    end else begin
      wb_data_q     <= '0;
      reg_wen_out_q <= 1'b0;
      jr_out_q      <= 1'b0;
      regd_out_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            alu_q        <= alu_result_in;
            load_q       <= dmem_alu_in & ~mem_wen_in;
            reg_wen_q    <= reg_wen_in;
            jr_q         <= jr_in;
            regd_q       <= regd_in;
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= mem_wen_in;
            dmem_addr_q  <= alu_result_in[ADDR_W+1:2];
            dmem_wdata_q <= store_data_in;
            state_q      <= S_WAIT;
          end else begin
            wb_data_q     <= alu_result_in;
            reg_wen_out_q <= reg_wen_in;
            jr_out_q      <= jr_in;
            regd_out_q    <= regd_in;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            dmem_req_q    <= 1'b0;
            wb_data_q     <= load_q ? dmem_rdata : alu_q;
            reg_wen_out_q <= reg_wen_q;
            jr_out_q      <= jr_q;
            regd_out_q    <= regd_q;
            state_q       <= S_IDLE;
          end else if (timeout_hit) begin
            dmem_req_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_data_out = wb_data_q;
  assign reg_wen_out = reg_wen_out_q;
  assign jr_out      = jr_out_q;
  assign regd_out    = regd_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, loads, stores, back-to-back, reset, timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic        reg_wen_in;
  logic        dmem_alu_in;
  logic        mem_wen_in;
  logic        jr_in;
  logic [4:0]  regd_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall_out;
  logic [31:0] wb_data_out;
  logic        reg_wen_out;
  logic        jr_out;
  logic [4:0]  regd_out;
  logic        dmem_err_out;

  int errors = 0;
  int checks = 0;

  mem_stage #(.ADDR_W(10), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .reg_wen_in(reg_wen_in), .dmem_alu_in(dmem_alu_in), .mem_wen_in(mem_wen_in),
    .jr_in(jr_in), .regd_in(regd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .wb_data_out(wb_data_out), .reg_wen_out(reg_wen_out),
    .jr_out(jr_out), .regd_out(regd_out), .dmem_err_out(dmem_err_out)
  );

  always #5 clk = ~clk;

  task automatic drive_nop();
    alu_result_in = 32'h0;
    store_data_in = 32'h0;
    reg_wen_in    = 1'b0;
    dmem_alu_in   = 1'b0;
    mem_wen_in    = 1'b0;
    jr_in         = 1'b0;
    regd_in       = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    alu_result_in = 32'h40; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd3;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0h expected 0", dmem_req); end
    checks++; if (wb_data_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb: got %0h expected 0", wb_data_out); end
    checks++; if (reg_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %0h expected 0", reg_wen_out); end
    checks++; if (regd_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_regd: got %0h expected 0", regd_out); end
    checks++; if (dmem_err_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0h expected 0", dmem_err_out); end
    rst = 1'b0;
    drive_nop();
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0h expected 0", stall_out); end
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    alu_result_in = 32'h1234; reg_wen_in = 1'b1; regd_in = 5'd5; jr_in = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %0h expected 0", stall_out); end
    @(negedge clk);
    drive_nop();
    dmem_ready = 1'b0;
    checks++; if (wb_data_out !== 32'h1234) begin errors++; $display("[TB] FAIL alu_wb: got %0h expected 1234", wb_data_out); end
    checks++; if (reg_wen_out !== 1'b1) begin errors++; $display("[TB] FAIL alu_wen: got %0h expected 1", reg_wen_out); end
    checks++; if (regd_out !== 5'd5) begin errors++; $display("[TB] FAIL alu_regd: got %0h expected 5", regd_out); end
    checks++; if (jr_out !== 1'b1) begin errors++; $display("[TB] FAIL alu_jr: got %0h expected 1", jr_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL alu_ready_ignored: got %0h expected 0", dmem_req); end
  endtask

  task automatic test_load();
    int stalls = 0;
    @(negedge clk);
    alu_result_in = 32'h40; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd7;
    dmem_rdata = 32'hBAD0BAD0;
    #1 stalls += int'(stall_out);
    @(negedge clk);
    drive_nop();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL load_req: got %0h expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL load_we: got %0h expected 0", dmem_we); end
    checks++; if (dmem_addr !== 10'h10) begin errors++; $display("[TB] FAIL load_addr: got %0h expected 10", dmem_addr); end
    checks++; if (reg_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL load_bubble1: got %0h expected 0", reg_wen_out); end
    #1 stalls += int'(stall_out);
    @(negedge clk);
    checks++; if (reg_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL load_bubble2: got %0h expected 0", reg_wen_out); end
    checks++; if (dmem_addr !== 10'h10) begin errors++; $display("[TB] FAIL load_addr_hold: got %0h expected 10", dmem_addr); end
    #1 stalls += int'(stall_out);
    @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 stalls += int'(stall_out);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL load_req_hold: got %0h expected 1", dmem_req); end
    @(negedge clk);
    dmem_ready = 1'b0; dmem_rdata = 32'hBAD0BAD0;
    checks++; if (wb_data_out !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_wb: got %0h expected deadbeef", wb_data_out); end
    checks++; if (reg_wen_out !== 1'b1) begin errors++; $display("[TB] FAIL load_wen: got %0h expected 1", reg_wen_out); end
    checks++; if (regd_out !== 5'd7) begin errors++; $display("[TB] FAIL load_regd: got %0h expected 7", regd_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL load_req_drop: got %0h expected 0", dmem_req); end
    checks++; if (stalls != 3) begin errors++; $display("[TB] FAIL load_stall_cycles: got %0d expected 3", stalls); end
  endtask

  task automatic test_store();
    @(negedge clk);
    alu_result_in = 32'h8; mem_wen_in = 1'b1; store_data_in = 32'hA5A5A5A5;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("[TB] FAIL store_stall_idle: got %0h expected 1", stall_out); end
    @(negedge clk);
    drive_nop();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL store_req: got %0h expected 1", dmem_req); end
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_we: got %0h expected 1", dmem_we); end
    checks++; if (dmem_addr !== 10'h2) begin errors++; $display("[TB] FAIL store_addr: got %0h expected 2", dmem_addr); end
    checks++; if (dmem_wdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL store_wdata: got %0h expected a5a5a5a5", dmem_wdata); end
    dmem_ready = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL store_stall_ready: got %0h expected 0", stall_out); end
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL store_req_drop: got %0h expected 0", dmem_req); end
    checks++; if (wb_data_out !== 32'h8) begin errors++; $display("[TB] FAIL store_wb: got %0h expected 8", wb_data_out); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    alu_result_in = 32'h100; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd3;
    @(negedge clk);
    drive_nop();
    checks++; if (dmem_addr !== 10'h40 || dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_load_addr: got %0h/%0h expected 40/0", dmem_addr, dmem_we); end
    dmem_ready = 1'b1; dmem_rdata = 32'h11112222;
    @(negedge clk);
    dmem_ready = 1'b0; dmem_rdata = 32'hBAD0BAD0;
    checks++; if (wb_data_out !== 32'h11112222 || regd_out !== 5'd3) begin errors++; $display("[TB] FAIL b2b_load_wb: got %0h/%0h expected 11112222/3", wb_data_out, regd_out); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0h expected 0", dmem_req); end
    alu_result_in = 32'h203; mem_wen_in = 1'b1; store_data_in = 32'h33334444;
    @(negedge clk);
    drive_nop();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 10'h80) begin errors++; $display("[TB] FAIL b2b_store_bus: got %0h/%0h/%0h expected 1/1/80", dmem_req, dmem_we, dmem_addr); end
    checks++; if (dmem_wdata !== 32'h33334444) begin errors++; $display("[TB] FAIL b2b_store_wdata: got %0h expected 33334444", dmem_wdata); end
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++; if (wb_data_out !== 32'h203 || reg_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_store_wb: got %0h/%0h expected 203/0", wb_data_out, reg_wen_out); end
    alu_result_in = 32'h55; reg_wen_in = 1'b1; regd_in = 5'd9;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_alu_stall: got %0h expected 0", stall_out); end
    @(negedge clk);
    drive_nop();
    checks++; if (wb_data_out !== 32'h55 || reg_wen_out !== 1'b1 || regd_out !== 5'd9) begin errors++; $display("[TB] FAIL b2b_alu_wb: got %0h/%0h/%0h expected 55/1/9", wb_data_out, reg_wen_out, regd_out); end
  endtask

  task automatic test_load_store_both();
    @(negedge clk);
    alu_result_in = 32'h24; dmem_alu_in = 1'b1; mem_wen_in = 1'b1; store_data_in = 32'h77; reg_wen_in = 1'b1; regd_in = 5'd2;
    @(negedge clk);
    drive_nop();
    checks++; if (dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL both_we: got %0h expected 1", dmem_we); end
    dmem_ready = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++; if (wb_data_out !== 32'h24) begin errors++; $display("[TB] FAIL both_wb: got %0h expected 24", wb_data_out); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    alu_result_in = 32'h80; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd6;
    @(negedge clk);
    drive_nop();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_req: got %0h expected 0", dmem_req); end
    checks++; if (wb_data_out !== 32'h0 || reg_wen_out !== 1'b0 || dmem_addr !== 10'h0) begin errors++; $display("[TB] FAIL rstwait_outs: got %0h/%0h/%0h expected 0/0/0", wb_data_out, reg_wen_out, dmem_addr); end
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("[TB] FAIL rstwait_stall: got %0h expected 0", stall_out); end
    alu_result_in = 32'hCAFE; reg_wen_in = 1'b1; regd_in = 5'd1;
    @(negedge clk);
    drive_nop();
    checks++; if (wb_data_out !== 32'hCAFE || reg_wen_out !== 1'b1) begin errors++; $display("[TB] FAIL rstwait_alu: got %0h/%0h expected cafe/1", wb_data_out, reg_wen_out); end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    alu_result_in = 32'h10; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd4;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive_nop();
      #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL to_req_c%0d: got %0h expected 1", k, dmem_req); end
      checks++; if (stall_out !== (k < 16)) begin errors++; $display("[TB] FAIL to_stall_c%0d: got %0h expected %0h", k, stall_out, (k < 16)); end
    end
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_req_drop: got %0h expected 0", dmem_req); end
    checks++; if (dmem_err_out !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %0h expected 1", dmem_err_out); end
    checks++; if (reg_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL to_bubble: got %0h expected 0", reg_wen_out); end
    alu_result_in = 32'h99; reg_wen_in = 1'b1; regd_in = 5'd8;
    repeat (3) @(negedge clk);
    drive_nop();
    checks++; if (dmem_err_out !== 1'b1) begin errors++; $display("[TB] FAIL to_err_sticky: got %0h expected 1", dmem_err_out); end
    checks++; if (wb_data_out !== 32'h99) begin errors++; $display("[TB] FAIL to_after_alu: got %0h expected 99", wb_data_out); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dmem_err_out !== 1'b0) begin errors++; $display("[TB] FAIL to_err_clear: got %0h expected 0", dmem_err_out); end
  endtask
`else
  task automatic test_no_timeout();
    @(negedge clk);
    alu_result_in = 32'h10; dmem_alu_in = 1'b1; reg_wen_in = 1'b1; regd_in = 5'd4;
    @(negedge clk);
    drive_nop();
    repeat (20) @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin errors++; $display("[TB] FAIL nto_hold: got %0h/%0h expected 1/1", dmem_req, stall_out); end
    checks++; if (dmem_err_out !== 1'b0) begin errors++; $display("[TB] FAIL nto_err: got %0h expected 0", dmem_err_out); end
    dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++; if (wb_data_out !== 32'h0BADF00D || regd_out !== 5'd4) begin errors++; $display("[TB] FAIL nto_wb: got %0h/%0h expected badf00d/4", wb_data_out, regd_out); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_nop();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_back_to_back();
    test_load_store_both();
    test_reset_in_wait();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
